lsu: RTL and testbench
======================

# lsu

Load/store unit in the MEM stage of the RV64I pipeline. It takes the effective address computed by the ALU (`ALUResult` of an ADD, or of SH1ADD through SH3ADD.UW for Zba) together with the store data and width from EX. It drives a single-port data-memory request/grant/response interface and returns sign- or zero-extended load data to writeback. While a memory operation is outstanding it stalls the upstream stages, and it reports misaligned accesses instead of issuing them.

## Interface
Parameters:
- `AW`, 64: address width.
- `DW`, 64: data and memory bus width. Fixed at 64; the bus is 8 bytes.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ex_valid`  in  1  EX holds a valid instruction.
- `ex_is_load`  in  1  instruction is a load.
- `ex_is_store`  in  1  instruction is a store.
- `ex_funct3`  in  3  RISC-V funct3. Bits [1:0] give the size (0=B, 1=H, 2=W, 3=D); bit [2] selects unsigned load.
- `ex_addr`  in  AW  effective address (ALU result).
- `ex_wdata`  in  DW  store data (rs2).
- `ex_rd`  in  5  destination register.
- `flush`  in  1  kill the accepted/outstanding operation.
- `lsu_busy`  out  1  stall request to IF/ID/EX.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  AW  8-byte-aligned address.
- `dmem_be`  out  8  byte enables.
- `dmem_wdata`  out  DW  lane-aligned store data.
- `dmem_gnt`  in  1  request accepted.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  DW  read data.
- `wb_valid`  out  1  load result valid, one-cycle pulse.
- `wb_rd`  out  5  destination of the load.
- `wb_data`  out  DW  extended load data.
- `misalign`  out  1  misaligned-access pulse.
- `misalign_addr`  out  AW  faulting address.

## Operation
- FSM states: IDLE, REQ, WAIT, DRAIN.
- **Accept.** In IDLE, when `ex_valid & (ex_is_load | ex_is_store) & ~flush`:
  - If the access is aligned, register address, size, type, `rd`, byte enables and shifted data, then go to REQ.
  - An access is aligned when `ex_addr & ((1<<size)-1) == 0`.
  - If the access is misaligned, issue no request, pulse `misalign` the next cycle with `misalign_addr = ex_addr`, and stay in IDLE.
- **Byte enables.** `dmem_be = ((1<<(1<<size))-1) << ex_addr[2:0]`.
- **Store data.** `dmem_wdata = ex_wdata << (8*ex_addr[2:0])`.
- **Address.** `dmem_addr = {ex_addr[AW-1:3], 3'b0}`.
- **REQ.**
  - `dmem_req=1` every cycle in REQ.
  - All `dmem_*` outputs stay stable until `dmem_gnt`.
  - On `gnt`, a store goes to IDLE and a load goes to WAIT.
- **WAIT.** On `dmem_rvalid`:
  - Select the lane by `addr[2:0]`.
  - Extend: sign-extend when `funct3[2]=0`, zero-extend when `funct3[2]=1`. LD ignores bit [2].
  - Register the result into `wb_data`, pulse `wb_valid`, and go to IDLE.
- **Flush.**
  - In REQ: go to IDLE and drop `dmem_req`. No grant occurs in that cycle; if `gnt` and `flush` coincide, the grant wins and the flush is treated as arriving in the next state.
  - In WAIT: go to DRAIN.
  - DRAIN absorbs one `dmem_rvalid`, suppresses `wb_valid`, then goes to IDLE.
- `dmem_rvalid` is ignored outside WAIT and DRAIN.
- Memory never asserts `rvalid` in the same cycle as `gnt`.
- `lsu_busy = (state != IDLE)`.
- **Reset.** Asynchronous assertion returns to IDLE and drops `dmem_req` immediately; in-flight data is discarded. All outputs reset to 0.

## Timing
- Accept at cycle T; `dmem_req` is high from T+1.
- Load with `gnt` at T+1 and `rvalid` at T+2: `wb_valid` at T+3. Minimum load latency is 3 cycles.
- Store with `gnt` at T+1: back to IDLE at T+2; a new op can be accepted at T+2.
- `misalign` is registered, high for exactly cycle T+1.
- `wb_valid` and `misalign` are single-cycle pulses.
- `wb_rd`, `wb_data` and `misalign_addr` hold their value until the next update.
- `lsu_busy` is registered-state derived. No combinational path from `dmem_*` inputs to `lsu_busy`.

## Structure
- Shared package `lsu_pkg`:
  - `lsu_state_e` (IDLE/REQ/WAIT/DRAIN).
  - Size constants `SZ_B`/`SZ_H`/`SZ_W`/`SZ_D`.
  - Funct3 constants for LB/LH/LW/LD/LBU/LHU/LWU/SB/SH/SW/SD.
- Sub-module `lsu_load_align`: combinational lane select plus sign/zero extension from `(rdata, addr[2:0], funct3)`. It is unit-testable in isolation.

## Test plan
- LD from 0x1000: `rdata=0xDEADBEEF_CAFEF00D`, `gnt` at T+1, `rvalid` at T+2 -> `wb_valid` at T+3, `wb_data=0xDEADBEEF_CAFEF00D`, `dmem_be=0xFF`.
- LB/LBU from 0x1003 with `rdata` byte3=0x80 -> `dmem_addr=0x1000`; LB yields `0xFFFF_FFFF_FFFF_FF80`, LBU yields `0x80`.
- SH to 0x2006 with `wdata=0x1234` -> `dmem_be=0xC0`, `dmem_wdata[63:48]=0x1234`, `dmem_we=1`.
- `gnt` held low for 4 cycles -> `dmem_req` and all outputs stable and `lsu_busy=1` for the whole wait; op completes after `gnt`.
- LW at 0x3002 -> no `dmem_req`, `misalign=1` at T+1, `misalign_addr=0x3002`, `lsu_busy` stays 0.
- Load in WAIT, then `flush`, then `rvalid` -> no `wb_valid`, state IDLE after `rvalid`. Separately, `rst_n` low during REQ -> `dmem_req=0` immediately and all outputs 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, size/funct3 constants and lane helpers for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = |off[1:0];
      default: bad = |off;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - single-port data-memory request/grant/response bus
interface lsu_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [7:0]    be;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - lane select and sign/zero extension of load data
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic [DW-1:0] rdata,
  input  logic [2:0]    addr_lo,
  input  logic [2:0]    funct3,
  output logic [DW-1:0] data
);

  logic [DW-1:0] lane;

  assign lane = rdata >> {addr_lo, 3'b000};

  // funct3 3'b111 has no load encoding; it falls through to a full doubleword
  always_comb begin
    data = lane;
    case (funct3)
      F3_LB:   data = {{(DW-8){lane[7]}}, lane[7:0]};
      F3_LH:   data = {{(DW-16){lane[15]}}, lane[15:0]};
      F3_LW:   data = {{(DW-32){lane[31]}}, lane[31:0]};
      F3_LBU:  data = {{(DW-8){1'b0}}, lane[7:0]};
      F3_LHU:  data = {{(DW-16){1'b0}}, lane[15:0]};
      F3_LWU:  data = {{(DW-32){1'b0}}, lane[31:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - MEM-stage load/store unit driving a single-port data memory
module lsu
  import lsu_pkg::*;
#(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  input  logic          ex_is_load,
  input  logic          ex_is_store,
  input  logic [2:0]    ex_funct3,
  input  logic [AW-1:0] ex_addr,
  input  logic [DW-1:0] ex_wdata,
  input  logic [4:0]    ex_rd,
  input  logic          flush,
  output logic          lsu_busy,
  lsu_if.master         dmem,
  output logic          wb_valid,
  output logic [4:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          misalign,
  output logic [AW-1:0] misalign_addr
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_REQ   = REQ;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]    state;
  logic [AW-1:0] addr_q;
  logic [2:0]    funct3_q;
  logic          we_q;
  logic [4:0]    rd_q;
  logic [7:0]    be_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] load_data;
  logic          accept;
  logic          bad_align;

  assign accept    = (state == S_IDLE) & ex_valid & (ex_is_load | ex_is_store) & ~flush;
  assign bad_align = is_misaligned(ex_funct3[1:0], ex_addr[2:0]);

  assign lsu_busy   = (state != S_IDLE);
  assign dmem.req   = (state == S_REQ);
  assign dmem.we    = we_q;
  assign dmem.addr  = {addr_q[AW-1:3], 3'b000};
  assign dmem.be    = be_q;
  assign dmem.wdata = wdata_q;

  lsu_load_align #(.DW(DW)) u_load_align (
    .rdata   (dmem.rdata),
    .addr_lo (addr_q[2:0]),
    .funct3  (funct3_q),
    .data    (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      funct3_q      <= '0;
      we_q          <= 1'b0;
      rd_q          <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (bad_align) begin
              misalign      <= 1'b1;
              misalign_addr <= ex_addr;
            end else begin
              addr_q   <= ex_addr;
              funct3_q <= ex_funct3;
              we_q     <= ex_is_store;
              rd_q     <= ex_rd;
              be_q     <= be_mask(ex_funct3[1:0], ex_addr[2:0]);
              wdata_q  <= ex_wdata << {ex_addr[2:0], 3'b000};
              state    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // a grant beats a coincident flush; a granted load must still drain its response
          if (dmem.gnt) begin
            if (we_q)       state <= S_IDLE;
            else if (flush) state <= S_DRAIN;
            else            state <= S_WAIT;
          end else if (flush) begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (dmem.rvalid) begin
            if (!flush) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= load_data;
            end
            state <= S_IDLE;
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        default: begin
          if (dmem.rvalid) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu against a byte-level memory reference
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_store = 1'b0, flush = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [63:0] ex_addr = '0, ex_wdata = '0;
  logic [4:0]  ex_rd = '0;
  logic        lsu_busy, wb_valid, misalign;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data, misalign_addr;

  always #5 clk = ~clk;

  lsu_if #(.AW(64), .DW(64)) dmem_bus ();

  lsu #(.AW(64), .DW(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_is_load    (ex_is_load),
    .ex_is_store   (ex_is_store),
    .ex_funct3     (ex_funct3),
    .ex_addr       (ex_addr),
    .ex_wdata      (ex_wdata),
    .ex_rd         (ex_rd),
    .flush         (flush),
    .lsu_busy      (lsu_busy),
    .dmem          (dmem_bus),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .misalign      (misalign),
    .misalign_addr (misalign_addr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // memory slave: 512-byte window, word storage, programmable grant/response delays
  logic [63:0] smem [0:63];
  logic [7:0]  ref_mem [0:511];
  int          gnt_delay = 0, rv_delay = 0, gcnt = 0, rv_cnt = 0;
  bit          rv_pending = 0;
  logic [63:0] rv_data;
  logic [5:0]  sidx;

  always @(negedge clk) begin
    dmem_bus.gnt = 1'b0;
    dmem_bus.rvalid = 1'b0;
    if (!rst_n) begin
      gcnt = 0;
      rv_pending = 0;
    end else if (rv_pending) begin
      if (rv_cnt == 0) begin
        dmem_bus.rvalid = 1'b1;
        dmem_bus.rdata = rv_data;
        rv_pending = 0;
      end else rv_cnt--;
    end else if (dmem_bus.req) begin
      if (gcnt >= gnt_delay) begin
        dmem_bus.gnt = 1'b1;
        gcnt = 0;
        sidx = dmem_bus.addr[8:3];
        if (dmem_bus.we) begin
          for (int b = 0; b < 8; b++)
            if (dmem_bus.be[b]) smem[sidx][8*b +: 8] = dmem_bus.wdata[8*b +: 8];
        end else begin
          rv_pending = 1;
          rv_cnt = rv_delay;
          rv_data = smem[sidx];
        end
      end else gcnt++;
    end else gcnt = 0;
  end

  task automatic poke(input logic [63:0] a, input logic [63:0] w);
    smem[a[8:3]] = w;
    for (int i = 0; i < 8; i++) ref_mem[{a[8:3], 3'b000} + 9'(i)] = w[8*i +: 8];
  endtask

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a);
    int n = 1 << f3[1:0];
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[(int'(a[8:0]) + i) % 512]) << (8 * i));
    if (n < 8 && !f3[2] && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    int n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) ref_mem[(int'(a[8:0]) + i) % 512] = wd[8*i +: 8];
  endtask

  function automatic logic [7:0] exp_be(input logic [63:0] a, input int n);
    logic [7:0] m = '0;
    int off = int'(a[2:0]);
    for (int i = 0; i < 8; i++) m[i] = (i >= off) && (i < off + n);
    return m;
  endfunction

  logic        r_req_seen, r_we, r_wb, r_mis, r_unstable, r_busy_seen, r_done, r_busy_drop;
  logic [63:0] r_addr, r_wdata, r_wb_data, r_mis_addr;
  logic [7:0]  r_be;
  logic [4:0]  r_wb_rd;
  int          r_cycles, r_req_cnt;

  task automatic drive_op(input bit st, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = !st; ex_is_store = st;
    ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
  endtask

  task automatic run_op(input bit st, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input logic [4:0] rd);
    r_req_seen = 0; r_wb = 0; r_mis = 0; r_unstable = 0; r_busy_seen = 0;
    r_done = 0; r_busy_drop = 0; r_cycles = 0; r_req_cnt = 0;
    drive_op(st, f3, a, wd, rd);
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) tick();
      r_cycles = c + 1;
      if (lsu_busy) r_busy_seen = 1;
      if (dmem_bus.req) begin
        r_req_cnt++;
        if (!lsu_busy) r_busy_drop = 1;
        if (!r_req_seen) begin
          r_req_seen = 1; r_we = dmem_bus.we; r_addr = dmem_bus.addr;
          r_be = dmem_bus.be; r_wdata = dmem_bus.wdata;
        end else if (r_we !== dmem_bus.we || r_addr !== dmem_bus.addr ||
                     r_be !== dmem_bus.be || r_wdata !== dmem_bus.wdata) r_unstable = 1;
      end
      if (wb_valid) begin r_wb = 1; r_wb_data = wb_data; r_wb_rd = wb_rd; end
      if (misalign) begin r_mis = 1; r_mis_addr = misalign_addr; end
      if (!lsu_busy) begin r_done = 1; break; end
    end
    check("op_done", r_done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          st, wbs, mis;
    logic [2:0]  f3;
    logic [63:0] a, wd;
    logic [4:0]  rd;
    int          n;

    dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0; dmem_bus.rdata = '0;
    for (int i = 0; i < 64; i++) poke(64'(i * 8), {$urandom, $urandom});

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", lsu_busy, 0);
    check("rst_req", dmem_bus.req, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_misalign", misalign, 0);
    rst_n = 1'b1;
    tick();

    // LD 0x1000, minimum latency
    poke(64'h1000, 64'hDEADBEEF_CAFEF00D);
    gnt_delay = 0; rv_delay = 0;
    drive_op(0, F3_LD, 64'h1000, 64'h0, 5'd5);
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    check("ld_req_t1", dmem_bus.req, 1);
    check("ld_be", dmem_bus.be, 8'hFF);
    check("ld_addr", dmem_bus.addr, 64'h1000);
    check("ld_busy", lsu_busy, 1);
    tick();
    check("ld_req_drop", dmem_bus.req, 0);
    check("ld_no_early_wb", wb_valid, 0);
    tick();
    check("ld_wb_valid_t3", wb_valid, 1);
    check("ld_wb_data", wb_data, 64'hDEADBEEF_CAFEF00D);
    check("ld_wb_rd", wb_rd, 5);
    check("ld_idle", lsu_busy, 0);
    tick();
    check("ld_wb_pulse", wb_valid, 0);
    check("ld_wb_hold", wb_data, 64'hDEADBEEF_CAFEF00D);

    // LB / LBU from 0x1003
    poke(64'h1000, 64'h01020304_80050607);
    run_op(0, F3_LB, 64'h1003, 64'h0, 5'd7);
    check("lb_addr", r_addr, 64'h1000);
    check("lb_data", r_wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    tick();
    run_op(0, F3_LBU, 64'h1003, 64'h0, 5'd8);
    check("lbu_data", r_wb_data, 64'h80);
    tick();

    // SH to 0x2006
    run_op(1, F3_SH, 64'h2006, 64'h1234, 5'd0);
    check("sh_be", r_be, 8'hC0);
    check("sh_wdata", r_wdata[63:48], 16'h1234);
    check("sh_we", r_we, 1);
    check("sh_cycles", r_cycles, 2);
    ref_store(F3_SH, 64'h2006, 64'h1234);
    tick();

    // grant held off for 4 cycles
    gnt_delay = 4;
    run_op(0, F3_LD, 64'h4020, 64'h0, 5'd3);
    check("hold_stable", r_unstable, 0);
    check("hold_req_cycles", r_req_cnt, 5);
    check("hold_busy", r_busy_drop, 0);
    check("hold_data", r_wb_data, ref_load(F3_LD, 64'h4020));
    gnt_delay = 0;
    tick();

    // misaligned LW
    run_op(0, F3_LW, 64'h3002, 64'h0, 5'd4);
    check("mis_pulse", r_mis, 1);
    check("mis_addr", r_mis_addr, 64'h3002);
    check("mis_noreq", r_req_seen, 0);
    check("mis_busy", r_busy_seen, 0);
    tick();
    check("mis_pulse_end", misalign, 0);

    // flush while waiting for the response
    rv_delay = 2;
    drive_op(0, F3_LW, 64'h4018, 64'h0, 5'd9);
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    tick();
    check("fw_busy", lsu_busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fw_drain_busy", lsu_busy, 1);
    wbs = 0; r_done = 0;
    for (int c = 0; c < 10; c++) begin
      if (wb_valid) wbs = 1;
      if (!lsu_busy) begin r_done = 1; break; end
      tick();
    end
    check("fw_no_wb", wbs, 0);
    check("fw_idle", r_done, 1);
    rv_delay = 0;
    tick();

    // flush while requesting
    gnt_delay = 3;
    drive_op(0, F3_LD, 64'h4010, 64'h0, 5'd2);
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fr_req", dmem_bus.req, 0);
    check("fr_busy", lsu_busy, 0);
    tick();

    // asynchronous reset during REQ
    drive_op(0, F3_LD, 64'h4008, 64'h0, 5'd6);
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    check("ar_req_before", dmem_bus.req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_req", dmem_bus.req, 0);
    check("ar_busy", lsu_busy, 0);
    check("ar_be", dmem_bus.be, 0);
    check("ar_addr", dmem_bus.addr, 0);
    check("ar_wb_data", wb_data, 0);
    check("ar_wb_rd", wb_rd, 0);
    check("ar_mis_addr", misalign_addr, 0);
    tick();
    rst_n = 1'b1;
    gnt_delay = 0;
    tick();

    // randomized loads/stores against the byte-level reference
    for (int k = 0; k < 200; k++) begin
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      n = 1 << f3[1:0];
      a = 64'h4000 + 64'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) a = a & ~64'(n - 1);
      mis = (a % 64'(n)) != 0;
      wd = {$urandom, $urandom};
      rd = 5'($urandom_range(1, 31));
      gnt_delay = $urandom_range(0, 2);
      rv_delay = $urandom_range(0, 2);
      run_op(st, f3, a, wd, rd);
      check("rnd_misalign", r_mis, mis);
      if (mis) begin
        check("rnd_mis_addr", r_mis_addr, a);
        check("rnd_mis_noreq", r_req_seen, 0);
      end else begin
        check("rnd_addr", r_addr, a & ~64'h7);
        check("rnd_be", r_be, exp_be(a, n));
        check("rnd_we", r_we, st);
        check("rnd_stable", r_unstable, 0);
        if (st) begin
          check("rnd_wdata", r_wdata, wd << (8 * a[2:0]));
          ref_store(f3, a, wd);
        end else begin
          check("rnd_wb_valid", r_wb, 1);
          check("rnd_ld_data", r_wb_data, ref_load(f3, a));
          check("rnd_ld_rd", r_wb_rd, rd);
        end
      end
      tick();
      check("rnd_pulses_low", {wb_valid, misalign}, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
